// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory stage of a five-stage pipeline, directly downstream of Execute.
// Registers the Execute results with their memory/writeback control bits,
// performs data-memory loads and stores over a req/ack handshake, and holds
// the upstream pipeline (Stall) while an access is outstanding. Produces
// registered writeback outputs: load data sign- or zero-extended, or the ALU
// result passed straight through.
//
// Parameters
//   TIMEOUT  cycles spent in ACCESS without Mem_Ack before the access aborts
//   CNT_W    width of the timeout counter (2**CNT_W > TIMEOUT)
//
// Ports
//   Clk, Reset            clock (rising edge), synchronous active-high reset
//   Valid_in              Execute presents a valid instruction
//   ALUResult_in          effective address or ALU result
//   StoreData_in          rt data for stores
//   RegDest_in            destination register from the RegDst mux
//   MemRead_in/MemWrite_in/RegWrite_in/MemToReg_in   control bits
//   MemSize_in            00 word, 01 half, 10 byte, 11 word
//   LoadUnsigned_in       1 = zero-extend loads (lbu/lhu)
//   Mem_Req/We/Addr/WData/ByteEn   registered data-memory request
//   Mem_Ack, Mem_RData    access complete, read word valid in the same cycle
//   Stall                 high while an access is outstanding
//   WB_Valid/Data/RegDest/RegWrite registered writeback outputs
//   Misaligned            one-cycle pulse on an alignment fault
//   Timeout_Err           sticky, cleared only by Reset
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Valid_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] StoreData_in,
  input  logic [4:0]  RegDest_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic [1:0]  MemSize_in,
  input  logic        LoadUnsigned_in,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  output logic [3:0]  Mem_ByteEn,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_RData,
  output logic        Stall,
  output logic        WB_Valid,
  output logic [31:0] WB_Data,
  output logic [4:0]  WB_RegDest,
  output logic        WB_RegWrite,
  output logic        Misaligned,
  output logic        Timeout_Err
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // State and captured instruction
  // ---------------------------------------------------------------------------
  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_alu;        // captured ALU result; [1:0] selects the lane
  logic [4:0]       r_regdest;
  logic             r_regwrite;
  logic             r_memtoreg;
  logic [1:0]       r_size;
  logic             r_unsigned;

  // ---------------------------------------------------------------------------
  // Request decode from the Execute inputs (used only at IDLE edges)
  // ---------------------------------------------------------------------------
  logic        w_is_mem;
  logic        w_misaligned;
  logic [3:0]  w_byte_en;
  logic [31:0] w_wdata;

  assign w_is_mem = MemRead_in | MemWrite_in;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_byte_en    = 4'b1111;
    w_wdata      = StoreData_in;
    w_misaligned = (ALUResult_in[1:0] != 2'b00);
    case (MemSize_in)
      SZ_BYTE: begin
        w_byte_en    = 4'b0001 << ALUResult_in[1:0];
        w_wdata      = {4{StoreData_in[7:0]}};
        w_misaligned = 1'b0;
      end
      SZ_HALF: begin
        w_byte_en    = ALUResult_in[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{StoreData_in[15:0]}};
        w_misaligned = ALUResult_in[0];
      end
      default: ;  // 00 and 11 are word accesses
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the returned word, using the captured address/size
  // ---------------------------------------------------------------------------
  logic [7:0]  w_rd_byte;
  logic [15:0] w_rd_half;
  logic [31:0] w_load_val;

  always_comb begin
    w_rd_byte  = Mem_RData[7:0];
    w_rd_half  = r_alu[1] ? Mem_RData[31:16] : Mem_RData[15:0];
    w_load_val = Mem_RData;
    case (r_alu[1:0])
      2'd1:    w_rd_byte = Mem_RData[15:8];
      2'd2:    w_rd_byte = Mem_RData[23:16];
      2'd3:    w_rd_byte = Mem_RData[31:24];
      default: w_rd_byte = Mem_RData[7:0];
    endcase
    case (r_size)
      SZ_BYTE: w_load_val = {{24{w_rd_byte[7] & ~r_unsigned}}, w_rd_byte};
      SZ_HALF: w_load_val = {{16{w_rd_half[15] & ~r_unsigned}}, w_rd_half};
      default: w_load_val = Mem_RData;
    endcase
  end

  // Stall follows the state register only, so it never depends on inputs.
  assign Stall = (r_state == S_ACCESS);

  // ---------------------------------------------------------------------------
  // Sequential control
  // ---------------------------------------------------------------------------
  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_alu       <= '0;
      r_regdest   <= '0;
      r_regwrite  <= 1'b0;
      r_memtoreg  <= 1'b0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      Mem_Req     <= 1'b0;
      Mem_We      <= 1'b0;
      Mem_Addr    <= '0;
      Mem_WData   <= '0;
      Mem_ByteEn  <= '0;
      WB_Valid    <= 1'b0;
      WB_Data     <= '0;
      WB_RegDest  <= '0;
      WB_RegWrite <= 1'b0;
      Misaligned  <= 1'b0;
      Timeout_Err <= 1'b0;
    end else begin
      Misaligned <= 1'b0;  // pulse: only the fault branch raises it

      case (r_state)
        S_IDLE: begin
          if (!Valid_in) begin
            WB_Valid <= 1'b0;
          end else if (!w_is_mem) begin
            // Non-memory instruction: one-cycle pass-through.
            WB_Valid    <= 1'b1;
            WB_Data     <= ALUResult_in;
            WB_RegDest  <= RegDest_in;
            WB_RegWrite <= RegWrite_in;
          end else if (w_misaligned) begin
            // Fault: no request, retire the instruction without a write.
            Misaligned  <= 1'b1;
            WB_Valid    <= 1'b1;
            WB_Data     <= ALUResult_in;
            WB_RegDest  <= RegDest_in;
            WB_RegWrite <= 1'b0;
          end else begin
            r_alu      <= ALUResult_in;
            r_regdest  <= RegDest_in;
            r_regwrite <= RegWrite_in;
            r_memtoreg <= MemToReg_in;
            r_size     <= MemSize_in;
            r_unsigned <= LoadUnsigned_in;
            Mem_Req    <= 1'b1;
            Mem_We     <= MemWrite_in;  // read+write together acts as a write
            Mem_Addr   <= {ALUResult_in[31:2], 2'b00};
            Mem_WData  <= w_wdata;
            Mem_ByteEn <= w_byte_en;
            r_cnt      <= '0;
            WB_Valid   <= 1'b0;
            r_state    <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          if (Mem_Ack) begin
            Mem_Req     <= 1'b0;
            WB_Valid    <= 1'b1;
            WB_Data     <= r_memtoreg ? w_load_val : r_alu;
            WB_RegDest  <= r_regdest;
            WB_RegWrite <= r_regwrite;
            r_state     <= S_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            // Abort: memory never answered, squash the instruction.
            Timeout_Err <= 1'b1;
            Mem_Req     <= 1'b0;
            WB_Valid    <= 1'b1;
            WB_Data     <= r_alu;
            WB_RegDest  <= r_regdest;
            WB_RegWrite <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Valid_in;
  logic [31:0] ALUResult_in;
  logic [31:0] StoreData_in;
  logic [4:0]  RegDest_in;
  logic        MemRead_in, MemWrite_in, RegWrite_in, MemToReg_in;
  logic [1:0]  MemSize_in;
  logic        LoadUnsigned_in;
  logic        Mem_Req, Mem_We;
  logic [31:0] Mem_Addr, Mem_WData;
  logic [3:0]  Mem_ByteEn;
  logic        Mem_Ack;
  logic [31:0] Mem_RData;
  logic        Stall, WB_Valid;
  logic [31:0] WB_Data;
  logic [4:0]  WB_RegDest;
  logic        WB_RegWrite, Misaligned, Timeout_Err;

  int errors = 0;
  int checks = 0;

  mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .Valid_in(Valid_in),
    .ALUResult_in(ALUResult_in), .StoreData_in(StoreData_in),
    .RegDest_in(RegDest_in), .MemRead_in(MemRead_in),
    .MemWrite_in(MemWrite_in), .RegWrite_in(RegWrite_in),
    .MemToReg_in(MemToReg_in), .MemSize_in(MemSize_in),
    .LoadUnsigned_in(LoadUnsigned_in), .Mem_Req(Mem_Req), .Mem_We(Mem_We),
    .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .Mem_ByteEn(Mem_ByteEn),
    .Mem_Ack(Mem_Ack), .Mem_RData(Mem_RData), .Stall(Stall),
    .WB_Valid(WB_Valid), .WB_Data(WB_Data), .WB_RegDest(WB_RegDest),
    .WB_RegWrite(WB_RegWrite), .Misaligned(Misaligned),
    .Timeout_Err(Timeout_Err)
  );

  always #5 Clk = ~Clk;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic rd, input logic wr,
                           input logic rw, input logic m2r,
                           input logic [1:0] sz, input logic uns,
                           input logic [31:0] alu, input logic [31:0] sd,
                           input logic [4:0] rdst);
    Valid_in = v; MemRead_in = rd; MemWrite_in = wr; RegWrite_in = rw;
    MemToReg_in = m2r; MemSize_in = sz; LoadUnsigned_in = uns;
    ALUResult_in = alu; StoreData_in = sd; RegDest_in = rdst;
  endtask

  task automatic clear_instr();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic test_reset();
    logic [113:0] all_out;
    Reset = 1'b1;
    clear_instr();
    Mem_Ack = 1'b0; Mem_RData = 32'h0;
    tick(); tick();
    all_out = {Mem_Req, Mem_We, Mem_Addr, Mem_WData, Mem_ByteEn, Stall,
               WB_Valid, WB_Data, WB_RegDest, WB_RegWrite, Misaligned, Timeout_Err};
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    Reset = 1'b0;
  endtask

  task automatic test_alu_passthrough();
    set_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h1234, 32'h0, 5'd5);
    checks++;
    if (Stall !== 1'b0) begin errors++; $display("FAIL alu_stall_before: got %b expected 0", Stall); end
    tick();
    checks++;
    if ({WB_Valid, WB_Data, WB_RegDest, WB_RegWrite, Stall} !== {1'b1, 32'h1234, 5'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL alu_wb: got v=%b d=%h rd=%0d rw=%b st=%b expected v=1 d=00001234 rd=5 rw=1 st=0",
               WB_Valid, WB_Data, WB_RegDest, WB_RegWrite, Stall);
    end
    clear_instr();
    tick();
    checks++;
    if (WB_Valid !== 1'b0) begin errors++; $display("FAIL alu_wb_pulse: got %b expected 0", WB_Valid); end
  endtask

  // lb at 0x103, ack arrives in the 4th ACCESS cycle.
  task automatic test_load_byte(input logic uns, input logic [31:0] exp_data);
    int stall_cycles;
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, uns, 32'h103, 32'h0, 5'd7);
    tick();
    clear_instr();
    checks++;
    if ({Mem_Req, Mem_We, Mem_Addr, Mem_ByteEn} !== {1'b1, 1'b0, 32'h100, 4'b1000}) begin
      errors++;
      $display("FAIL lb_request: got req=%b we=%b addr=%h be=%b expected req=1 we=0 addr=00000100 be=1000",
               Mem_Req, Mem_We, Mem_Addr, Mem_ByteEn);
    end
    stall_cycles = 0;
    for (int c = 1; c <= 4; c++) begin
      if (Stall === 1'b1) stall_cycles++;
      if (c == 4) begin Mem_Ack = 1'b1; Mem_RData = 32'h80FF_FFFF; end
      tick();
    end
    Mem_Ack = 1'b0; Mem_RData = 32'h0;
    checks++;
    if (stall_cycles != 4 || Stall !== 1'b0) begin
      errors++; $display("FAIL lb_stall_cycles: got %0d (now %b) expected 4 (now 0)", stall_cycles, Stall);
    end
    checks++;
    if ({WB_Valid, WB_Data, WB_RegDest, WB_RegWrite, Mem_Req} !== {1'b1, exp_data, 5'd7, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL lb_wb(uns=%b): got v=%b d=%h rd=%0d rw=%b req=%b expected v=1 d=%h rd=7 rw=1 req=0",
               uns, WB_Valid, WB_Data, WB_RegDest, WB_RegWrite, Mem_Req, exp_data);
    end
    tick();
  endtask

  task automatic test_store_half();
    set_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h202, 32'hAAAA_BEEF, 5'd0);
    tick();
    clear_instr();
    checks++;
    if ({Mem_Req, Mem_We, Mem_Addr, Mem_ByteEn, Mem_WData} !== {1'b1, 1'b1, 32'h200, 4'b1100, 32'hBEEF_BEEF}) begin
      errors++;
      $display("FAIL sh_request: got req=%b we=%b addr=%h be=%b wd=%h expected req=1 we=1 addr=00000200 be=1100 wd=beefbeef",
               Mem_Req, Mem_We, Mem_Addr, Mem_ByteEn, Mem_WData);
    end
    Mem_Ack = 1'b1;
    tick();
    Mem_Ack = 1'b0;
    checks++;
    if ({WB_Valid, WB_RegWrite, Stall, Mem_Req} !== 4'b1000) begin
      errors++;
      $display("FAIL sh_best_case: got v=%b rw=%b st=%b req=%b expected v=1 rw=0 st=0 req=0",
               WB_Valid, WB_RegWrite, Stall, Mem_Req);
    end
    tick();
  endtask

  // sb at 0x001 with both MemRead and MemWrite set: must act as a write.
  task automatic test_store_byte_rw();
    set_instr(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h001, 32'h1234_565A, 5'd0);
    tick();
    clear_instr();
    checks++;
    if ({Mem_We, Mem_Addr, Mem_ByteEn, Mem_WData} !== {1'b1, 32'h0, 4'b0010, 32'h5A5A_5A5A}) begin
      errors++;
      $display("FAIL sb_request: got we=%b addr=%h be=%b wd=%h expected we=1 addr=00000000 be=0010 wd=5a5a5a5a",
               Mem_We, Mem_Addr, Mem_ByteEn, Mem_WData);
    end
    Mem_Ack = 1'b1;
    tick();
    Mem_Ack = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h101, 32'h0, 5'd9);
    tick();
    clear_instr();
    checks++;
    if ({Mem_Req, Misaligned, WB_Valid, WB_RegWrite, Stall} !== 5'b01100) begin
      errors++;
      $display("FAIL lw_misaligned: got req=%b mis=%b v=%b rw=%b st=%b expected req=0 mis=1 v=1 rw=0 st=0",
               Mem_Req, Misaligned, WB_Valid, WB_RegWrite, Stall);
    end
    tick();
    checks++;
    if ({Misaligned, WB_Valid} !== 2'b00) begin
      errors++; $display("FAIL misaligned_pulse: got mis=%b v=%b expected 0 0", Misaligned, WB_Valid);
    end
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'h203, 32'h0, 5'd9);
    tick();
    clear_instr();
    checks++;
    if ({Mem_Req, Misaligned} !== 2'b01) begin
      errors++; $display("FAIL lh_misaligned: got req=%b mis=%b expected req=0 mis=1", Mem_Req, Misaligned);
    end
    tick();
  endtask

  task automatic test_timeout();
    int req_cycles;
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h40, 32'h0, 5'd3);
    tick();
    clear_instr();
    req_cycles = 0;
    while (Mem_Req === 1'b1 && req_cycles < 40) begin
      req_cycles++;
      tick();
    end
    checks++;
    if (req_cycles != 16) begin
      errors++; $display("FAIL timeout_req_cycles: got %0d expected 16", req_cycles);
    end
    checks++;
    if ({Timeout_Err, Stall, WB_Valid, WB_RegWrite} !== 4'b1010) begin
      errors++;
      $display("FAIL timeout_abort: got err=%b st=%b v=%b rw=%b expected err=1 st=0 v=1 rw=0",
               Timeout_Err, Stall, WB_Valid, WB_RegWrite);
    end
    set_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h55, 32'h0, 5'd4);
    tick();
    clear_instr();
    checks++;
    if ({WB_Valid, WB_Data, WB_RegWrite, Timeout_Err} !== {1'b1, 32'h55, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL timeout_next_instr: got v=%b d=%h rw=%b err=%b expected v=1 d=00000055 rw=1 err=1",
               WB_Valid, WB_Data, WB_RegWrite, Timeout_Err);
    end
    tick();
  endtask

  task automatic test_reset_in_access();
    logic [113:0] all_out;
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h80, 32'h0, 5'd6);
    tick();
    clear_instr();
    tick();  // now in the 2nd ACCESS cycle
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    all_out = {Mem_Req, Mem_We, Mem_Addr, Mem_WData, Mem_ByteEn, Stall,
               WB_Valid, WB_Data, WB_RegDest, WB_RegWrite, Misaligned, Timeout_Err};
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_in_access: got %h expected 0", all_out);
    end
    Mem_Ack = 1'b1; Mem_RData = 32'h1111_2222;
    tick();
    Mem_Ack = 1'b0;
    checks++;
    if ({WB_Valid, Mem_Req, Stall} !== 3'b000) begin
      errors++;
      $display("FAIL late_ack_ignored: got v=%b req=%b st=%b expected 0 0 0", WB_Valid, Mem_Req, Stall);
    end
  endtask

  // lw then lh held on the inputs during the stall; lh must be sampled only
  // at the first edge after returning to IDLE.
  task automatic test_back_to_back();
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 5'd1);
    tick();
    checks++;
    if ({Mem_Req, Mem_Addr, Mem_ByteEn} !== {1'b1, 32'h10, 4'b1111}) begin
      errors++;
      $display("FAIL b2b_lw_req: got req=%b addr=%h be=%b expected req=1 addr=00000010 be=1111",
               Mem_Req, Mem_Addr, Mem_ByteEn);
    end
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'h16, 32'h0, 5'd2);
    Mem_Ack = 1'b1; Mem_RData = 32'hDEAD_BEEF;
    tick();
    Mem_Ack = 1'b0;
    checks++;
    if ({WB_Valid, WB_Data, WB_RegDest, Mem_Req, Stall} !== {1'b1, 32'hDEAD_BEEF, 5'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_lw_wb: got v=%b d=%h rd=%0d req=%b st=%b expected v=1 d=deadbeef rd=1 req=0 st=0",
               WB_Valid, WB_Data, WB_RegDest, Mem_Req, Stall);
    end
    tick();
    clear_instr();
    checks++;
    if ({Mem_Req, Mem_Addr, Mem_ByteEn, WB_Valid} !== {1'b1, 32'h14, 4'b1100, 1'b0}) begin
      errors++;
      $display("FAIL b2b_lh_req: got req=%b addr=%h be=%b v=%b expected req=1 addr=00000014 be=1100 v=0",
               Mem_Req, Mem_Addr, Mem_ByteEn, WB_Valid);
    end
    Mem_Ack = 1'b1; Mem_RData = 32'h8001_1234;
    tick();
    Mem_Ack = 1'b0;
    checks++;
    if ({WB_Valid, WB_Data, WB_RegDest} !== {1'b1, 32'hFFFF_8001, 5'd2}) begin
      errors++;
      $display("FAIL b2b_lh_wb: got v=%b d=%h rd=%0d expected v=1 d=ffff8001 rd=2",
               WB_Valid, WB_Data, WB_RegDest);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_passthrough();
    test_load_byte(1'b0, 32'hFFFF_FF80);
    test_load_byte(1'b1, 32'h0000_0080);
    test_store_half();
    test_store_byte_rw();
    test_misaligned();
    test_timeout();
    test_reset_in_access();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage directly downstream of Execute.
- Registers Execute results (ALU result, store data, selected destination register) together with the memory/writeback control bits.
- Performs data-memory loads and stores over a req/ack handshake, and stalls the upstream pipeline while an access is outstanding.
- Produces registered writeback outputs: load data sign- or zero-extended, or the ALU result passed through.

Parameters:
- TIMEOUT, 16: maximum cycles in ACCESS without Mem_Ack before the access is aborted.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- Clk  input  1  clock, rising edge
- Reset  input  1  synchronous, active-high
- Valid_in  input  1  Execute presents a valid instruction
- ALUResult_in  input  32  effective address or ALU result
- StoreData_in  input  32  rt register data for stores
- RegDest_in  input  5  destination register from the RegDst mux
- MemRead_in, MemWrite_in, RegWrite_in, MemToReg_in  input  1 each  control bits
- MemSize_in  input  2  access size: 00 word, 01 half, 10 byte, 11 treated as word
- LoadUnsigned_in  input  1  1 = zero-extend loads (lbu/lhu)
- Mem_Req  output  1  memory request
- Mem_We  output  1  1 = write
- Mem_Addr  output  32  {addr[31:2],2'b00}
- Mem_WData  output  32  lane-replicated store data
- Mem_ByteEn  output  4  byte lane enables, bit k = bits 8k+7:8k
- Mem_Ack  input  1  access complete; Mem_RData valid in the same cycle
- Mem_RData  input  32  read word
- Stall  output  1  hold the upstream pipeline
- WB_Valid  output  1  writeback outputs valid (one-cycle pulse)
- WB_Data  output  32  writeback value
- WB_RegDest  output  5  writeback register
- WB_RegWrite  output  1  writeback enable
- Misaligned  output  1  one-cycle pulse on an alignment fault
- Timeout_Err  output  1  sticky; cleared only by Reset

Behaviour:
- Reset: state IDLE and every output 0, including the timeout counter. Reset overrides everything; Reset during ACCESS drops Mem_Req at that edge.
- States: IDLE, ACCESS.
- Stall = (state == ACCESS), combinational from the state.
- Inputs are sampled only at an IDLE edge; no input is sampled while Stall is high.

IDLE, at each edge:
- Valid_in=0: WB_Valid<=0.
- Valid with MemRead=MemWrite=0: WB_Valid<=1, WB_Data<=ALUResult_in, WB_RegDest/WB_RegWrite copied. Latency is 1 cycle.
- Valid with a memory operation and the address aligned: capture all inputs, then go to ACCESS. Mem_Req, Mem_We, Mem_Addr, Mem_WData and Mem_ByteEn are registered and held stable until exit. Counter<=0, WB_Valid<=0.
- MemRead and MemWrite both 1: treated as a write.
- Misaligned access (half with addr[0]=1, word with addr[1:0]!=0): no request is issued; Misaligned<=1 and WB_Valid<=1 with WB_RegWrite<=0, both for one cycle.

ACCESS:
- Mem_Ack=1: go to IDLE, Mem_Req<=0, WB_Valid<=1. WB_Data is the extracted load value when MemToReg=1, otherwise the captured ALUResult. WB_RegWrite is the captured value.
- Mem_Ack=0: increment the counter. When the counter reaches TIMEOUT-1 without Mem_Ack, Timeout_Err<=1, Mem_Req<=0, go to IDLE, and WB_Valid<=1 with WB_RegWrite<=0 (instruction squashed).
- Mem_Ack seen while IDLE is ignored.

Lanes (little-endian, k=addr[1:0]):
- Byte: ByteEn=1<<k, WData={4{sd[7:0]}}.
- Half: ByteEn=addr[1]?4'b1100:4'b0011, WData={2{sd[15:0]}}.
- Word: ByteEn=4'b1111, WData=sd.
- Reads drive ByteEn with the same pattern.

Load extract:
- Byte = RData[8k+7:8k]; half = RData[16*addr[1]+15 : 16*addr[1]].
- Extended by the sign bit, or by zero if LoadUnsigned.

Throughput:
- Best case, ack in the first ACCESS cycle: WB_Valid one edge after the request edge. Stall is high for exactly 1 cycle.
- Back-to-back memory ops: the next instruction is sampled at the first edge after returning to IDLE.

Test Plan:
- Non-memory op: Valid, ALUResult_in=0x1234, RegDest=5, RegWrite=1 -> next cycle WB_Valid=1, WB_Data=0x1234, WB_RegDest=5, Stall never high.
- lb at addr 0x103, ack after 3 cycles, RData=0x80FFFFFF -> Mem_Addr=0x100, ByteEn=1000, Stall high 4 cycles, WB_Data=0xFFFFFF80; same with LoadUnsigned -> 0x00000080.
- sh at addr 0x202, StoreData=0xAAAABEEF -> Mem_We=1, ByteEn=1100, WData=0xBEEFBEEF, WB_RegWrite=0.
- lw at addr 0x101 -> no Mem_Req, Misaligned pulses 1 cycle, WB_RegWrite=0.
- lw, Mem_Ack never asserted, TIMEOUT=16 -> Mem_Req drops after 16 cycles, Timeout_Err stays 1, Stall low; next instruction accepted.
- Reset asserted on the 2nd ACCESS cycle -> next edge all outputs 0, state IDLE; a late Mem_Ack has no effect.
